// File: rtl/alu_issue_ctrl.sv
// Register-file sequencer driving a combinational alu: accept, issue, writeback.
// Optional immediate operand B enabled by ALU_ISSUE_CTRL_IMM_EN.
module alu_issue_ctrl #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_src_a,
  input  logic [AW-1:0]    cmd_src_b,
  input  logic [AW-1:0]    cmd_dst,
`ifdef ALU_ISSUE_CTRL_IMM_EN
  input  logic             cmd_use_imm,
  input  logic [WIDTH-1:0] cmd_imm,
`endif
  output logic [WIDTH-1:0] bus_a,
  output logic [WIDTH-1:0] bus_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             zero,
  input  logic             negative,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_negative
);

  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] bus_a_q, bus_a_d;
  logic [WIDTH-1:0] bus_b_q, bus_b_d;
  logic [2:0]       sel_q, sel_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic             rv_q, rv_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             rz_q, rz_d;
  logic             rn_q, rn_d;
  logic [WIDTH-1:0] op_a, op_b;

  // Same-edge host writes bypass into the operand snapshot.
  always_comb begin
    op_a = (wr_en && wr_addr == cmd_src_a) ? wr_data : regs_q[cmd_src_a];
    op_b = (wr_en && wr_addr == cmd_src_b) ? wr_data : regs_q[cmd_src_b];
`ifdef ALU_ISSUE_CTRL_IMM_EN
    if (cmd_use_imm) op_b = cmd_imm;
`endif
  end

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    bus_a_d = bus_a_q;
    bus_b_d = bus_b_q;
    sel_d   = sel_q;
    dst_d   = dst_q;
    rv_d    = 1'b0;
    rd_d    = rd_q;
    rz_d    = rz_q;
    rn_d    = rn_q;
    if (wr_en) regs_d[wr_addr] = wr_data;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = ISSUE;
          bus_a_d = op_a;
          bus_b_d = op_b;
          sel_d   = cmd_op;
          dst_d   = cmd_dst;
        end
      end
      ISSUE: begin
        state_d        = WB;
        regs_d[dst_q]  = alu_out;
        rv_d           = 1'b1;
        rd_d           = alu_out;
        rz_d           = zero;
        rn_d           = negative;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      bus_a_q <= '0;
      bus_b_q <= '0;
      sel_q   <= '0;
      dst_q   <= '0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
      rz_q    <= 1'b0;
      rn_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      bus_a_q <= bus_a_d;
      bus_b_q <= bus_b_d;
      sel_q   <= sel_d;
      dst_q   <= dst_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
      rz_q    <= rz_d;
      rn_q    <= rn_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign bus_a        = bus_a_q;
  assign bus_b        = bus_b_q;
  assign alu_sel      = sel_q;
  assign res_valid    = rv_q;
  assign res_data     = rd_q;
  assign res_zero     = rz_q;
  assign res_negative = rn_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: transaction-level model, per-cycle compare,
// directed cases and random traffic.
module tb_alu_issue_ctrl;
  localparam int W  = 8;
  localparam int NR = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0] wr_data = '0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [AW-1:0] cmd_src_a = '0, cmd_src_b = '0, cmd_dst = '0;
  logic cmd_use_imm = 1'b0;
  logic [W-1:0] cmd_imm = '0;
  logic [W-1:0] bus_a, bus_b, alu_out, res_data;
  logic [2:0] alu_sel;
  logic zero, negative, res_valid, res_zero, res_negative;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(W), .NREGS(NR)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src_a(cmd_src_a),
    .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
`ifdef ALU_ISSUE_CTRL_IMM_EN
    .cmd_use_imm(cmd_use_imm), .cmd_imm(cmd_imm),
`endif
    .bus_a(bus_a), .bus_b(bus_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .zero(zero), .negative(negative),
    .res_valid(res_valid), .res_data(res_data),
    .res_zero(res_zero), .res_negative(res_negative)
  );

  function automatic logic [W-1:0] alu_fn(input logic [2:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return {a[W-1], a[W-1:1]};
      default: return b;
    endcase
  endfunction

  assign alu_out  = alu_fn(alu_sel, bus_a, bus_b);
  assign zero     = (alu_out == '0);
  assign negative = alu_out[W-1];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  // Reference: registers, snapshotted operands, cycles left in command.
  logic [W-1:0] m_regs [NR];
  logic [W-1:0] m_a = '0, m_b = '0, m_rd = '0;
  logic [2:0] m_sel = '0;
  logic [AW-1:0] m_dst = '0;
  logic m_rv = 1'b0, m_rz = 1'b0, m_rn = 1'b0;
  int m_left = 0;

  task automatic model_step();
    logic [W-1:0] r, na, nb;
    logic acc, wb;
    if (rst) begin
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_a = '0; m_b = '0; m_sel = '0; m_dst = '0;
      m_rv = 0; m_rd = '0; m_rz = 0; m_rn = 0; m_left = 0;
      return;
    end
    r   = alu_fn(m_sel, m_a, m_b);
    wb  = (m_left == 2);
    acc = cmd_valid && (m_left == 0);
    na  = (wr_en && wr_addr == cmd_src_a) ? wr_data : m_regs[cmd_src_a];
    nb  = (wr_en && wr_addr == cmd_src_b) ? wr_data : m_regs[cmd_src_b];
`ifdef ALU_ISSUE_CTRL_IMM_EN
    if (cmd_use_imm) nb = cmd_imm;
`endif
    if (wr_en) m_regs[wr_addr] = wr_data;
    if (wb) m_regs[m_dst] = r;
    if (acc) begin
      m_a = na; m_b = nb; m_sel = cmd_op; m_dst = cmd_dst;
    end
    m_rv = wb;
    if (wb) begin
      m_rd = r; m_rz = (r == '0); m_rn = r[W-1];
    end
    m_left = acc ? 2 : (m_left > 0 ? m_left - 1 : 0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    forever begin
      @(posedge clk or posedge rst);
      model_step();
      #1;
      chk("cmd_ready", cmd_ready, m_left == 0);
      chk("bus_a", bus_a, m_a);
      chk("bus_b", bus_b, m_b);
      chk("alu_sel", alu_sel, m_sel);
      chk("res_valid", res_valid, m_rv);
      chk("res_data", res_data, m_rd);
      chk("res_zero", res_zero, m_rz);
      chk("res_negative", res_negative, m_rn);
    end
  end

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] a,
                       input logic [AW-1:0] b, input logic [AW-1:0] d,
                       input logic h0e, input logic [AW-1:0] h0a,
                       input logic [W-1:0] h0d,
                       input logic h1e, input logic [AW-1:0] h1a,
                       input logic [W-1:0] h1d,
                       input logic ui, input logic [W-1:0] im,
                       output logic [W-1:0] r);
    int n = 0;
    while (!cmd_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("ready_timeout", cmd_ready, 1);
    cmd_valid = 1; cmd_op = op;
    cmd_src_a = a; cmd_src_b = b; cmd_dst = d;
    cmd_use_imm = ui; cmd_imm = im;
    wr_en = h0e; wr_addr = h0a; wr_data = h0d;
    @(negedge clk);
    cmd_valid = 0; cmd_use_imm = 0;
    wr_en = h1e; wr_addr = h1a; wr_data = h1d;
    @(negedge clk);
    wr_en = 0;
    chk("res_pulse", res_valid, 1);
    r = res_data;
  endtask

  task automatic run(input logic [2:0] op, input logic [AW-1:0] a,
                     input logic [AW-1:0] b, input logic [AW-1:0] d,
                     output logic [W-1:0] r);
    issue(op, a, b, d, 0, 0, 0, 0, 0, 0, 0, 0, r);
  endtask

  logic [W-1:0] r;

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_bus_a", bus_a, 0);
    chk("rst_bus_b", bus_b, 0);
    chk("rst_alu_sel", alu_sel, 0);
    for (int i = 0; i < NR; i++) begin
      run(3'd0, AW'(i), AW'(i), AW'(i), r);
      chk("rst_reg", r, 0);
    end

    wr(0, 5); wr(1, 10);
    run(3'd0, 0, 1, 2, r);
    chk("add_res", r, 15);
    chk("add_zero", res_zero, 0);
    chk("add_neg", res_negative, 0);
    chk("add_bus_a", bus_a, 5);
    chk("add_bus_b", bus_b, 10);
    run(3'd0, 2, 3, 3, r);
    chk("add_r2", r, 15);

    wr(0, 30); wr(1, 10);
    run(3'd1, 0, 1, 0, r);
    chk("sub_first", r, 20);
    run(3'd1, 0, 1, 0, r);
    chk("sub_second", r, 10);

    issue(3'd0, 0, 1, 3, 1, 1, 7, 0, 0, 0, 0, 0, r);
    chk("bypass_bus_b", bus_b, 7);
    chk("bypass_res", r, 17);
    issue(3'd0, 0, 1, 2, 0, 0, 0, 1, 2, 99, 0, 0, r);
    chk("collide_res", r, 17);
    run(3'd0, 2, 2, 3, r);
    chk("collide_reg", r, 34);
    issue(3'd0, 0, 0, 3, 0, 0, 0, 1, 1, 50, 0, 0, r);
    chk("other_wr_res", r, 20);
    run(3'd0, 1, 1, 3, r);
    chk("other_wr_reg", r, 100);

    wr(2, 9);
    cmd_valid = 1; cmd_op = 3'd0;
    cmd_src_a = 2; cmd_src_b = 2; cmd_dst = 1;
    @(negedge clk);
    cmd_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_ready", cmd_ready, 1);
    repeat (3) begin
      chk("abort_no_pulse", res_valid, 0);
      @(negedge clk);
    end
    run(3'd0, 1, 1, 0, r);
    chk("abort_dst", r, 0);

`ifdef ALU_ISSUE_CTRL_IMM_EN
    wr(0, 3);
    issue(3'd0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 1, 8'hFD, r);
    chk("imm_res", r, 0);
    chk("imm_zero", res_zero, 1);
`endif

    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 79) == 0);
      wr_en       = $urandom_range(0, 2) == 0;
      wr_addr     = AW'($urandom_range(0, NR - 1));
      wr_data     = W'($urandom);
      cmd_valid   = $urandom_range(0, 1) == 1;
      cmd_op      = 3'($urandom);
      cmd_src_a   = AW'($urandom_range(0, NR - 1));
      cmd_src_b   = AW'($urandom_range(0, NR - 1));
      cmd_dst     = AW'($urandom_range(0, NR - 1));
      cmd_use_imm = $urandom_range(0, 1) == 1;
      cmd_imm     = W'($urandom);
    end
    @(negedge clk);
    rst = 0; cmd_valid = 0; wr_en = 0; cmd_use_imm = 0;
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
